// File: rtl/arith_pkg.sv
// Shared sign-magnitude definitions for the lane's arithmetic units.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SM_W       = 16;
  localparam int SM_SIGN    = SM_W - 1;
  localparam int SM_MAG_MSB = SM_W - 2;

  function automatic logic sm_sign(input logic [SM_W-1:0] v);
    return v[SM_SIGN];
  endfunction

  function automatic logic [SM_MAG_MSB:0] sm_mag(input logic [SM_W-1:0] v);
    return v[SM_MAG_MSB:0];
  endfunction

endpackage

// File: rtl/divide_unit_if.sv
// Issue-side start/done handshake and operand/result bus of the divider.
interface divide_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] c;
  logic         cout;
  logic         zero;
  logic         overflow;
  logic         neg;

  modport master (
    output start, a, b,
    input  busy, done, c, cout, zero, overflow, neg
  );

  modport slave (
    input  start, a, b,
    output busy, done, c, cout, zero, overflow, neg
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore.
module div_step
  import arith_pkg::*;
#(
  parameter int MAG_W = SM_MAG_MSB + 1
) (
  input  logic [MAG_W-1:0] rem_i,
  input  logic             msb_i,
  input  logic [MAG_W-1:0] div_i,
  output logic [MAG_W-1:0] next_rem_o,
  output logic             q_bit_o
);
  logic [MAG_W:0] shifted;
  logic [MAG_W:0] diff;

  assign shifted = {rem_i, msb_i};
  assign diff    = shifted - {1'b0, div_i};

  // rem_i < div_i always holds, so the borrow bit alone tells whether the trial fits
  assign q_bit_o    = ~diff[MAG_W];
  assign next_rem_o = q_bit_o ? diff[MAG_W-1:0] : shifted[MAG_W-1:0];
endmodule

// File: rtl/divide_unit.sv
// Iterative sign-magnitude divider, one quotient bit per clock.
// Build option DIVIDE_REMAINDER_EN packs the signed remainder into c[N-1:W].
module divide_unit
  import arith_pkg::*;
#(
  parameter int N = 32,
  parameter int W = SM_W
) (
  input logic          clk,
  input logic          rst_n,
  divide_unit_if.slave bus
);
  localparam int MAG_W = W - 1;
  localparam int CNT_W = $clog2(W);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] dvd_q, dvd_d;
  logic [MAG_W-1:0] div_q, div_d;
  logic [MAG_W-1:0] rem_q, rem_d;
  logic             sign_q, sign_d;
  logic [N-1:0]     c_q, c_d;
  logic             cout_q, cout_d, zero_q, zero_d;
  logic             ovf_q, ovf_d, neg_q, neg_d, done_q, done_d;
`ifdef DIVIDE_REMAINDER_EN
  logic             dsign_q, dsign_d;
`endif
  logic [MAG_W-1:0] step_rem;
  logic             step_q;
  logic [MAG_W-1:0] mag;
  logic             unused_hi;

  assign unused_hi = ^{bus.a[N-1:W], bus.b[N-1:W]};

  div_step #(.MAG_W(MAG_W)) u_step (
    .rem_i      (rem_q),
    .msb_i      (dvd_q[MAG_W-1]),
    .div_i      (div_q),
    .next_rem_o (step_rem),
    .q_bit_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    c_d     = c_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    mag     = '0;
`ifdef DIVIDE_REMAINDER_EN
    dsign_d = dsign_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d  = sm_mag(bus.a[W-1:0]);
          div_d  = sm_mag(bus.b[W-1:0]);
          rem_d  = '0;
          sign_d = sm_sign(bus.a[W-1:0]) ^ sm_sign(bus.b[W-1:0]);
`ifdef DIVIDE_REMAINDER_EN
          dsign_d = sm_sign(bus.a[W-1:0]);
`endif
          cnt_d   = CNT_W'(W - 1);
          state_d = (sm_mag(bus.b[W-1:0]) == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[MAG_W-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        ovf_d   = (div_q == '0);
        mag     = ovf_d ? '1 : dvd_q;
        cout_d  = !ovf_d && (rem_q != '0);
        zero_d  = (mag == '0);
        neg_d   = sign_q && (mag != '0);
        c_d          = '0;
        c_d[MAG_W-1:0] = mag;
        c_d[W-1]     = neg_d;
`ifdef DIVIDE_REMAINDER_EN
        c_d[W+MAG_W-1:W] = rem_q;
        c_d[N-1]         = dsign_q && (rem_q != '0);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIVIDE_REMAINDER_EN
      dsign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
`ifdef DIVIDE_REMAINDER_EN
      dsign_q <= dsign_d;
`endif
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.c        = c_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.neg      = neg_q;
endmodule

// File: tb/tb_divide_unit.sv
// Bench for divide_unit: fixed vectors, multi-cycle corner sequences, random vs model.
module tb_divide_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  divide_unit_if #(.N(N)) bus ();
  divide_unit #(.N(N), .W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] c_rem;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic        neg;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer division on the magnitudes
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic cout,
                                output logic zero, output logic ovf, output logic neg);
    int unsigned ma, mb, q, r;
    ma = 32'(a[14:0]);
    mb = 32'(b[14:0]);
    if (mb == 0) begin
      q = 32'h7FFF; r = 0; ovf = 1'b1;
    end else begin
      q = ma / mb; r = ma % mb; ovf = 1'b0;
    end
    neg  = (a[15] ^ b[15]) && (q != 0);
    cout = (r != 0);
    zero = (q == 0);
    c = q | (neg ? 32'h8000 : 32'h0);
`ifdef DIVIDE_REMAINDER_EN
    c = c | (r << 16);
    if (a[15] && r != 0) c = c | 32'h8000_0000;
`endif
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] c, input logic cout,
                               input logic zero, input logic ovf, input logic neg);
    check({tag, "_c"}, 64'(bus.c), 64'(c));
    check({tag, "_cout"}, 64'(bus.cout), 64'(cout));
    check({tag, "_zero"}, 64'(bus.zero), 64'(zero));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(ovf));
    check({tag, "_neg"}, 64'(bus.neg), 64'(neg));
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_c"}, 64'(bus.c), 64'd0);
    check({tag, "_flags"}, 64'({bus.cout, bus.zero, bus.overflow, bus.neg}), 64'd0);
  endtask

  initial begin
    int lat, first, second, ndone;
    logic [31:0] ec, cap_c, hold_c;
    logic ecout, ezero, eovf, eneg;
    logic [31:0] ra, rb;

    vecs[0]  = '{32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0002_000E, 1'b1, 1'b0, 1'b0, 1'b0, 16};
    vecs[1]  = '{32'h0000_8064, 32'h0000_0007, 32'h0000_800E, 32'h8002_800E, 1'b1, 1'b0, 1'b0, 1'b1, 16};
    vecs[2]  = '{32'h0000_8003, 32'h0000_000A, 32'h0000_0000, 32'h8003_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16};
    vecs[3]  = '{32'h0000_0005, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[4]  = '{32'h0000_7FFF, 32'h0000_0001, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vecs[5]  = '{32'h0000_0009, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vecs[6]  = '{32'hABCD_0064, 32'h1234_0007, 32'h0000_000E, 32'h0002_000E, 1'b1, 1'b0, 1'b0, 1'b0, 16};
    vecs[7]  = '{32'h0000_8000, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 16};
    vecs[8]  = '{32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{32'h0000_0003, 32'h0000_8005, 32'h0000_0000, 32'h0003_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_div(vecs[k].a, vecs[k].b, lat);
      check($sformatf("vec%0d_lat", k), 64'(lat), 64'(vecs[k].lat));
`ifdef DIVIDE_REMAINDER_EN
      ec = vecs[k].c_rem;
`else
      ec = vecs[k].c;
`endif
      check_outputs($sformatf("vec%0d", k), ec, vecs[k].cout, vecs[k].zero, vecs[k].ovf, vecs[k].neg);
    end

    // start pulsed during CALC must be ignored
    @(negedge clk);
    bus.a = 32'h7FFF; bus.b = 32'h1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    first = -1; ndone = 0; cap_c = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin bus.a = 32'h2; bus.b = 32'h1; bus.start = 1'b1; end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first < 0) begin first = i; cap_c = bus.c; end
      end
    end
    model(32'h7FFF, 32'h1, ec, ecout, ezero, eovf, eneg);
    check("busy_start_lat", 64'(first), 64'd16);
    check("busy_start_ndone", 64'(ndone), 64'd1);
    check("busy_start_c", 64'(cap_c), 64'(ec));

    // start held high: back-to-back divisions, result held during the second
    @(negedge clk);
    bus.a = 32'h64; bus.b = 32'h7; bus.start = 1'b1;
    @(posedge clk);
    first = -1; second = -1; ndone = 0; hold_c = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i == 20) hold_c = bus.c;
      if (i == 33) bus.start = 1'b0;
    end
    model(32'h64, 32'h7, ec, ecout, ezero, eovf, eneg);
    check("held_first", 64'(first), 64'd16);
    check("held_second", 64'(second), 64'd33);
    check("held_ndone", 64'(ndone), 64'd2);
    check("held_c_hold", 64'(hold_c), 64'(ec));

    // reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    bus.a = 32'h64; bus.b = 32'h7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (bus.done) ndone++;
    end
    check("midreset_no_done", 64'(ndone), 64'd0);
    run_div(32'h9, 32'h3, lat);
    check("after_reset_lat", 64'(lat), 64'd16);
    model(32'h9, 32'h3, ec, ecout, ezero, eovf, eneg);
    check_outputs("after_reset", ec, ecout, ezero, eovf, eneg);

    for (int it = 0; it < 150; it++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb[14:0] = '0;
      else if ($urandom_range(0, 3) == 0) rb[14:0] = 15'($urandom_range(1, 15));
      model(ra, rb, ec, ecout, ezero, eovf, eneg);
      run_div(ra, rb, lat);
      check($sformatf("rnd%0d_lat", it), 64'(lat), (rb[14:0] == 0) ? 64'd1 : 64'd16);
      check_outputs($sformatf("rnd%0d", it), ec, ecout, ezero, eovf, eneg);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/divide_unit.md
Name: divide_unit

Overview:
Iterative sign-magnitude integer divider. It is the inverse operation of the team's combinational multiply unit.
- Operand format matches the multiply unit: bit 15 is the sign, bits 14:0 are the magnitude, and bits 31:16 of the inputs are ignored.
- Computes quotient a/b with a restoring algorithm at one quotient bit per clock.
- Sits beside the multiply unit in the ALU/vector lane and is driven by a start/done handshake from the issue logic.
- Produces flag outputs with the same names and meaning as the other arithmetic units.

Parameters:
N, 32, bus width of a, b, c.
W, 16, sign-magnitude field width; magnitude is W-1 bits, sign is bit W-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  N  dividend; bits W-1:0 used.
b  input  N  divisor; bits W-1:0 used.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle pulse; c and flags are valid from this cycle.
c  output  N  result: c[W-2:0] quotient magnitude, c[W-1] sign, c[N-1:W] = 0 (see Optional Feature).
cout  output  1  remainder nonzero (inexact result).
zero  output  1  quotient magnitude == 0.
overflow  output  1  divide by zero.
neg  output  1  equals c[W-1].

Behaviour:
- Reset is asynchronous on rst_n low. State goes to IDLE; busy, done, c, cout, zero, overflow and neg all go to 0.
- Reset asserted mid-operation aborts the division. No done pulse is produced.
- States:
  - IDLE: if start=1, latch |a|, |b| and sign a[W-1]^b[W-1]. If |b|==0 go to DONE, otherwise go to CALC with cnt=W-1.
  - CALC: shift the {rem,dividend} pair left by 1 and trial-subtract |b|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise set it to 0. Decrement cnt. When cnt reaches 1 at this step, go to DONE.
  - DONE: assert done for exactly one cycle, update c and flags, then go to IDLE.
- Latency:
  - Normal case: start is sampled at edge 0; CALC runs W-1 = 15 cycles; done is high in the cycle following edge 16.
  - Divide by zero: done is high in the cycle following edge 1.
- Results: c and flags are registered at the DONE transition. They hold until the next DONE or reset and are not cleared by a new start.
- Sign: c[W-1] = sign, except it is forced to 0 when the quotient magnitude is 0 (no negative zero).
- Divide by zero: quotient magnitude = all ones (0x7FFF), sign per the rule above, overflow=1, cout=0.
- Otherwise overflow=0. Magnitude division of 15-bit values cannot overflow.
- start while busy is ignored. Operands are not re-latched.
- start held high continuously: a new division begins in the IDLE cycle after DONE.

Optional Feature:
Macro DIVIDE_REMAINDER_EN.
- Defined: c[W+W-2:W] = remainder magnitude and c[N-1] = dividend sign (forced 0 if the remainder is 0). Remaining upper bits are 0.
- Undefined: c[N-1:W] = 0. The remainder register still exists internally for cout.

Decomposition:
- Shared package (arith_pkg): state enum (IDLE, CALC, DONE), the SM_W=16 constant, and the sign-bit and magnitude-slice localparams. The multiply unit can reuse these.
- One sub-module: div_step, a combinational shift/trial-subtract/restore stage producing {next_rem, q_bit}.
- The FSM and counter stay in divide_unit.

Test Plan:
- a=0x0064 (100), b=0x0007, start pulse -> done exactly 16 cycles later; c=0x0000000E, cout=1, zero=0, neg=0, overflow=0.
- a=0x8064, b=0x0007 -> c=0x0000800E, neg=1, cout=1. With DIVIDE_REMAINDER_EN: c=0x8002800E.
- a=0x8003, b=0x000A -> c=0x00000000, zero=1, neg=0 (sign forced), cout=1.
- a=0x0005, b=0x8000 (magnitude 0) -> done 1 cycle after the start edge; c=0x0000FFFF, overflow=1, cout=0.
- Start a=0x7FFF, b=0x0001; pulse start with a=0x0002, b=0x0001 during CALC -> single done with c=0x00007FFF; second request ignored.
- Assert rst_n low 5 cycles into CALC, then release -> all outputs 0, no done pulse; a following start a=0x0009, b=0x0003 yields c=0x00000003, cout=0.
